// File: rtl/chip8_timer_regs_pkg.sv
// Shared CHIP-8 timer definitions, used by the tick generator, CPU and timer block.
package chip8_timer_regs_pkg;

    // Width of the delay and sound timers.
    localparam int unsigned TIMER_W = 8;

    // Rate of the timer tick pulse.
    localparam int unsigned TICK_HZ = 60;

    // Clocks per buzzer half-period for a given system clock and tone.
    function automatic int unsigned half_period(input int unsigned clock_hz,
                                                input int unsigned tone_hz);
        return clock_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/chip8_tone_gen.sv
// Square-wave tone generator: toggles out every HALF_PER clocks while enabled.
// Disabled forces out low and reloads the counter, so every tone starts with a full low half-period.
module chip8_tone_gen #(
    parameter int unsigned HALF_PER = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic out
);

    localparam logic [31:0] Reload = 32'(HALF_PER - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        out_q, out_d;

    // Next-state: count down while enabled, toggle and reload on reaching zero.
    always_comb begin
        cnt_d = Reload;
        out_d = 1'b0;
        if (enable) begin
            if (cnt_q == 32'd0) begin
                cnt_d = Reload;
                out_d = ~out_q;
            end else begin
                cnt_d = cnt_q - 32'd1;
                out_d = out_q;
            end
        end
    end

    // Counter and toggle flop with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= Reload;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/chip8_timer_regs.sv
// CHIP-8 delay and sound timers: loaded by the CPU, decremented by the 60 Hz tick,
// with a buzzer tone while the sound timer is non-zero.
module chip8_timer_regs
    import chip8_timer_regs_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 12000000,
    parameter int unsigned TONE_HZ  = 440
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_60hz,
    input  logic               wr_dt,
    input  logic               wr_st,
    input  logic [TIMER_W-1:0] wr_data,
    output logic [TIMER_W-1:0] dt_value,
    output logic [TIMER_W-1:0] st_value,
    output logic               sound_active,
    output logic               dt_expired,
    output logic               buzzer
);

    localparam int unsigned HALF_PER = half_period(CLOCK_HZ, TONE_HZ);
    localparam logic [TIMER_W-1:0] TimerOne = TIMER_W'(1);

    logic [TIMER_W-1:0] dt_q, dt_d;
    logic [TIMER_W-1:0] st_q, st_d;
    logic               expired_q, expired_d;

    // Write beats tick for the same timer; a zero timer never wraps.
    always_comb begin
        dt_d = dt_q;
        st_d = st_q;
        if (wr_dt) begin
            dt_d = wr_data;
        end else if (tick_60hz && (dt_q != '0)) begin
            dt_d = dt_q - TimerOne;
        end
        if (wr_st) begin
            st_d = wr_data;
        end else if (tick_60hz && (st_q != '0)) begin
            st_d = st_q - TimerOne;
        end
        // Only a real tick-driven 1->0 transition counts as expiry.
        expired_d = tick_60hz && !wr_dt && (dt_q == TimerOne);
    end

    // Timer registers and expiry pulse flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dt_q      <= '0;
            st_q      <= '0;
            expired_q <= 1'b0;
        end else begin
            dt_q      <= dt_d;
            st_q      <= st_d;
            expired_q <= expired_d;
        end
    end

    assign dt_value     = dt_q;
    assign st_value     = st_q;
    assign dt_expired   = expired_q;
    assign sound_active = (st_q != '0);

    chip8_tone_gen #(
        .HALF_PER (HALF_PER)
    ) u_tone_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (sound_active),
        .out    (buzzer)
    );

endmodule

// File: tb/tb_chip8_timer_regs.sv
// Self-checking bench for chip8_timer_regs: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model.
module tb_chip8_timer_regs;

    localparam int unsigned HalfPer = 5;  // 1000 / (2 * 100)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_60hz = 1'b0;
    logic       wr_dt = 1'b0;
    logic       wr_st = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] dt_value;
    logic [7:0] st_value;
    logic       sound_active;
    logic       dt_expired;
    logic       buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_dt = 0;
    int m_st = 0;
    int m_exp = 0;
    int m_sound_clks = 0;  // clock edges seen with the sound timer non-zero since it last was zero

    chip8_timer_regs #(
        .CLOCK_HZ (1000),
        .TONE_HZ  (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_60hz    (tick_60hz),
        .wr_dt        (wr_dt),
        .wr_st        (wr_st),
        .wr_data      (wr_data),
        .dt_value     (dt_value),
        .st_value     (st_value),
        .sound_active (sound_active),
        .dt_expired   (dt_expired),
        .buzzer       (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare every output.
    task automatic step(input bit rst, input bit tick, input bit wdt, input bit wst,
                        input int data);
        int buz;
        rst_n     = ~rst;
        tick_60hz = tick;
        wr_dt     = wdt;
        wr_st     = wst;
        wr_data   = data[7:0];
        @(posedge clk);
        if (rst) begin
            m_dt = 0;
            m_st = 0;
            m_exp = 0;
            m_sound_clks = 0;
        end else begin
            m_sound_clks = (m_st != 0) ? m_sound_clks + 1 : 0;
            m_exp = (tick && !wdt && m_dt == 1) ? 1 : 0;
            if (wdt) m_dt = data & 255;
            else if (tick && m_dt > 0) m_dt = m_dt - 1;
            if (wst) m_st = data & 255;
            else if (tick && m_st > 0) m_st = m_st - 1;
        end
        #1;
        buz = (m_sound_clks / HalfPer) % 2;
        check_eq("dt_value", int'(dt_value), m_dt);
        check_eq("st_value", int'(st_value), m_st);
        check_eq("sound_active", int'(sound_active), (m_st != 0) ? 1 : 0);
        check_eq("dt_expired", int'(dt_expired), m_exp);
        check_eq("buzzer", int'(buzzer), buz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        // Reset and idle ticks.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 0);
            idle(2);
        end

        // DT countdown with expiry pulse, plus a tick at zero.
        step(1'b0, 1'b0, 1'b1, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            idle(9);
            step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        idle(3);

        // Write and tick on the same edge.
        step(1'b0, 1'b0, 1'b1, 1'b0, 5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16);
        idle(2);
        // Write overriding a 1->0 decrement must not expire.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        idle(2);

        // Tone start, run, and stop after two ticks.
        step(1'b0, 1'b0, 1'b0, 1'b1, 2);
        idle(23);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle(12);

        // Reload ST mid half-period keeps the tone phase.
        step(1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle(7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 9);
        idle(15);

        // Reset while sounding, then silence until the next write.
        step(1'b0, 1'b0, 1'b1, 1'b0, 7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(12);

        // Random traffic, biased toward small values so timers reach zero often.
        for (int i = 0; i < 3000; i++) begin
            bit rst, tick, wdt, wst;
            int data;
            rst  = ($urandom_range(0, 199) == 0);
            tick = ($urandom_range(0, 5) == 0);
            wdt  = ($urandom_range(0, 19) == 0);
            wst  = ($urandom_range(0, 24) == 0);
            data = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 4));
            step(rst, tick, wdt, wst, data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
